// File: rtl/axi_ni_send_response_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_ni_send_response_capture_if
//  Description : Bundles the AXI B/R response channels and the holding-register
//                side-band toward the packetizer.
//                slave  modport - the capture block (consumes B/R, drives resp_*)
//                master modport - the environment (drives B/R, consumes resp_*)
//  Ports       : BID/BRESP/BVALID/BREADY         AXI write-response channel
//                RID/RDATA/RRESP/RLAST/RVALID/RREADY AXI read-data channel
//                resp_valid/is_read/id/data/code/last/beat, resp_accept
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_ni_send_response_capture_if #(
  parameter int AXIRDATAWD = 32,
  parameter int AXIIDWD    = 4
);
  logic [AXIIDWD-1:0]    BID;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [AXIIDWD-1:0]    RID;
  logic [AXIRDATAWD-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  logic                  resp_valid;
  logic                  resp_is_read;
  logic [AXIIDWD-1:0]    resp_id;
  logic [AXIRDATAWD-1:0] resp_data;
  logic [1:0]            resp_code;
  logic                  resp_last;
  logic [7:0]            resp_beat;
  logic                  resp_accept;

  modport slave (
    input  BID, BRESP, BVALID,
    output BREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output resp_valid, resp_is_read, resp_id, resp_data, resp_code, resp_last, resp_beat,
    input  resp_accept
  );

  modport master (
    output BID, BRESP, BVALID,
    input  BREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  resp_valid, resp_is_read, resp_id, resp_data, resp_code, resp_last, resp_beat,
    output resp_accept
  );
endinterface
`default_nettype wire

// File: rtl/axi_ni_send_response_capture.sv
`default_nettype none
// ============================================================================
//  Module      : axi_ni_send_response_capture
//  Description : Captures AXI write responses (B) and read beats (R) into a
//                single-entry holding register for the network packetizer.
//                Round-robin between B and R when idle; once a read burst is
//                open only R is served so the burst stays contiguous.
//  Ports       : clk_i  - clock, all state on rising edge
//                rst_i  - asynchronous active-high reset
//                bus    - slave modport of axi_ni_send_response_capture_if
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_ni_send_response_capture #(
  parameter int AXIRDATAWD = 32,
  parameter int AXIIDWD    = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  axi_ni_send_response_capture_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RBURST = 1'b1
  } state_t;

  localparam logic LG_B = 1'b0;
  localparam logic LG_R = 1'b1;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;

  logic                  resp_valid_q,   resp_valid_d;
  logic                  resp_is_read_q, resp_is_read_d;
  logic [AXIIDWD-1:0]    resp_id_q,      resp_id_d;
  logic [AXIRDATAWD-1:0] resp_data_q,    resp_data_d;
  logic [1:0]            resp_code_q,    resp_code_d;
  logic                  resp_last_q,    resp_last_d;
  logic [7:0]            resp_beat_q,    resp_beat_d;

  logic                  grant_b, grant_r;
  logic                  free;
  logic                  bready, rready;
  logic                  b_hs, r_hs;

  // --------------------------------------------------------------------------
  // Arbitration and handshakes
  // --------------------------------------------------------------------------
  always_comb begin
    grant_b = 1'b0;
    grant_r = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.BVALID && bus.RVALID) begin
          // Tie: serve the channel that did not win the last handshake
          grant_b = (last_grant_q == LG_R);
          grant_r = (last_grant_q == LG_B);
        end else begin
          grant_b = bus.BVALID;
          grant_r = bus.RVALID;
        end
      end
      ST_RBURST: begin
        grant_r = bus.RVALID;
      end
      default: begin
        grant_b = 1'b0;
        grant_r = 1'b0;
      end
    endcase
  end

  // The register may be refilled in the same cycle it is popped
  assign free   = ~resp_valid_q | bus.resp_accept;
  // READYs are forced low while reset is held
  assign bready = free & grant_b & ~rst_i;
  assign rready = free & grant_r & ~rst_i;
  assign b_hs   = bready & bus.BVALID;
  assign r_hs   = rready & bus.RVALID;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    beat_cnt_d     = beat_cnt_q;
    resp_valid_d   = resp_valid_q;
    resp_is_read_d = resp_is_read_q;
    resp_id_d      = resp_id_q;
    resp_data_d    = resp_data_q;
    resp_code_d    = resp_code_q;
    resp_last_d    = resp_last_q;
    resp_beat_d    = resp_beat_q;

    if (resp_valid_q && bus.resp_accept) begin
      resp_valid_d = 1'b0;
    end

    if (b_hs) begin
      resp_valid_d   = 1'b1;
      resp_is_read_d = 1'b0;
      resp_id_d      = bus.BID;
      resp_data_d    = '0;
      resp_code_d    = bus.BRESP;
      resp_last_d    = 1'b1;
      resp_beat_d    = 8'd0;
      last_grant_d   = LG_B;
    end

    if (r_hs) begin
      resp_valid_d   = 1'b1;
      resp_is_read_d = 1'b1;
      resp_id_d      = bus.RID;
      resp_data_d    = bus.RDATA;
      resp_code_d    = bus.RRESP;
      resp_last_d    = bus.RLAST;
      resp_beat_d    = beat_cnt_q;
      last_grant_d   = LG_R;
      if (bus.RLAST) begin
        beat_cnt_d = 8'd0;
        state_d    = ST_IDLE;
      end else begin
        // 8-bit counter wraps 255 -> 0 naturally
        beat_cnt_d = beat_cnt_q + 8'd1;
        state_d    = ST_RBURST;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= LG_R;
      beat_cnt_q     <= 8'd0;
      resp_valid_q   <= 1'b0;
      resp_is_read_q <= 1'b0;
      resp_id_q      <= '0;
      resp_data_q    <= '0;
      resp_code_q    <= 2'd0;
      resp_last_q    <= 1'b0;
      resp_beat_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      beat_cnt_q     <= beat_cnt_d;
      resp_valid_q   <= resp_valid_d;
      resp_is_read_q <= resp_is_read_d;
      resp_id_q      <= resp_id_d;
      resp_data_q    <= resp_data_d;
      resp_code_q    <= resp_code_d;
      resp_last_q    <= resp_last_d;
      resp_beat_q    <= resp_beat_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.BREADY       = bready;
  assign bus.RREADY       = rready;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_is_read = resp_is_read_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_code    = resp_code_q;
  assign bus.resp_last    = resp_last_q;
  assign bus.resp_beat    = resp_beat_q;

endmodule
`default_nettype wire
